// File: rtl/boa_stage_id.sv
// Boa32 ID stage: IF/ID register, RV32I decode and static prediction (BTFN on BRANCH when BOA_BTFN_PREDICT_EN).
// Latency: 1 cycle d_* -> q_*; fw_branch_predict is combinational from the ID register.
// Backpressure: fw_stall_id holds the register and is mirrored on fw_stall_if; clear beats stall.
`ifndef RV_ECAUSE_IALIGN
`define RV_ECAUSE_IALIGN 4'd0
`endif
`ifndef RV_ECAUSE_IINSN
`define RV_ECAUSE_IINSN 4'd2
`endif

module boa_stage_id (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        d_valid,
  input  logic [31:1] d_pc,
  input  logic [31:0] d_insn,
  input  logic        d_trap,
  input  logic [3:0]  d_cause,
  output logic        q_valid,
  output logic [31:1] q_pc,
  output logic [31:0] q_insn,
  output logic [4:0]  q_rs1,
  output logic [4:0]  q_rs2,
  output logic [4:0]  q_rd,
  output logic [31:0] q_imm,
  output logic        q_predicted,
  output logic        q_trap,
  output logic [3:0]  q_cause,
  input  logic        fw_stall_id,
  output logic        fw_stall_if,
  output logic        fw_branch_predict,
  output logic [31:1] fw_branch_target
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  logic        r_valid;
  logic        r_trap;
  logic [3:0]  r_cause;
  logic [31:1] r_pc;
  logic [31:0] r_insn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_trap  <= 1'b0;
      r_cause <= 4'd0;
      r_pc    <= '0;
      r_insn  <= 32'h0000_0013;
    end else begin
      if (!fw_stall_id) begin
        r_valid <= d_valid;
        r_trap  <= d_trap;
        r_cause <= d_cause;
        r_pc    <= d_pc;
        r_insn  <= d_insn;
      end
      // clear overrides both load and hold
      if (clear) begin
        r_valid <= 1'b0;
        r_trap  <= 1'b0;
      end
    end
  end

  logic [4:0]  opc;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        has_rd, has_rs1, has_rs2;
  logic        illegal, is_jal, is_branch, taken;
  logic [31:0] imm;

  assign opc    = r_insn[6:2];
  assign funct3 = r_insn[14:12];
  assign funct7 = r_insn[31:25];

  always_comb begin
    has_rd    = 1'b0;
    has_rs1   = 1'b0;
    has_rs2   = 1'b0;
    illegal   = 1'b0;
    is_jal    = 1'b0;
    is_branch = 1'b0;
    imm       = 32'd0;
    if (r_insn[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opc)
        OPC_LUI, OPC_AUIPC: begin
          has_rd = 1'b1;
          imm    = {r_insn[31:12], 12'd0};
        end
        OPC_JAL: begin
          has_rd = 1'b1;
          is_jal = 1'b1;
          imm    = {{12{r_insn[31]}}, r_insn[19:12], r_insn[20], r_insn[30:21], 1'b0};
        end
        OPC_JALR, OPC_LOAD, OPC_MISC, OPC_SYSTEM: begin
          has_rd  = 1'b1;
          has_rs1 = 1'b1;
          imm     = {{20{r_insn[31]}}, r_insn[31:20]};
        end
        OPC_OPIMM: begin
          has_rd  = 1'b1;
          has_rs1 = 1'b1;
          imm     = {{20{r_insn[31]}}, r_insn[31:20]};
          // shift-immediate encodings reuse the upper imm bits as funct7
          if (funct3 == 3'b001 && funct7 != 7'b0000000)
            illegal = 1'b1;
          if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
            illegal = 1'b1;
        end
        OPC_BRANCH: begin
          has_rs1   = 1'b1;
          has_rs2   = 1'b1;
          is_branch = 1'b1;
          imm       = {{20{r_insn[31]}}, r_insn[7], r_insn[30:25], r_insn[11:8], 1'b0};
        end
        OPC_STORE: begin
          has_rs1 = 1'b1;
          has_rs2 = 1'b1;
          imm     = {{20{r_insn[31]}}, r_insn[31:25], r_insn[11:7]};
        end
        OPC_OP: begin
          has_rd  = 1'b1;
          has_rs1 = 1'b1;
          has_rs2 = 1'b1;
          if (!(funct7 == 7'b0000000 ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
            illegal = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

`ifdef BOA_BTFN_PREDICT_EN
  assign taken = is_jal || (is_branch && imm[31]);
`else
  assign taken = is_jal || (is_branch && 1'b0);
`endif

  assign q_valid           = r_valid && !illegal && !r_trap;
  assign q_trap            = (r_valid && illegal) || r_trap;
  assign q_cause           = r_trap ? r_cause : ((r_valid && illegal) ? `RV_ECAUSE_IINSN : 4'd0);
  assign q_pc              = r_pc;
  assign q_insn            = r_insn;
  assign q_rs1             = has_rs1 ? r_insn[19:15] : 5'd0;
  assign q_rs2             = has_rs2 ? r_insn[24:20] : 5'd0;
  assign q_rd              = has_rd  ? r_insn[11:7]  : 5'd0;
  assign q_imm             = imm;
  assign q_predicted       = taken && q_valid;
  assign fw_stall_if       = fw_stall_id;
  assign fw_branch_predict = q_valid && !fw_stall_id && !clear && taken;
  assign fw_branch_target  = r_pc + imm[31:1];

endmodule

// File: tb/tb_boa_stage_id.sv
// Directed bench for boa_stage_id: expectations queued at drive time, popped and asserted after each edge.
`ifndef RV_ECAUSE_IALIGN
`define RV_ECAUSE_IALIGN 4'd0
`endif
`ifndef RV_ECAUSE_IINSN
`define RV_ECAUSE_IINSN 4'd2
`endif

module tb_boa_stage_id;

  logic        clk = 1'b0;
  logic        rst, clear, d_valid, d_trap, fw_stall_id;
  logic [31:1] d_pc;
  logic [31:0] d_insn;
  logic [3:0]  d_cause;
  logic        q_valid, q_predicted, q_trap, fw_stall_if, fw_branch_predict;
  logic [31:1] q_pc, fw_branch_target;
  logic [31:0] q_insn, q_imm;
  logic [4:0]  q_rs1, q_rs2, q_rd;
  logic [3:0]  q_cause;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        v;
    logic [31:1] pc;
    logic [31:0] insn;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        pred, trap;
    logic [3:0]  cause;
    logic        fwp;
    logic [31:1] tgt;
  } exp_t;

  exp_t sb[$];

`ifdef BOA_BTFN_PREDICT_EN
  localparam logic BTFN = 1'b1;
`else
  localparam logic BTFN = 1'b0;
`endif

  boa_stage_id dut (
    .clk(clk), .rst(rst), .clear(clear),
    .d_valid(d_valid), .d_pc(d_pc), .d_insn(d_insn), .d_trap(d_trap), .d_cause(d_cause),
    .q_valid(q_valid), .q_pc(q_pc), .q_insn(q_insn), .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
    .q_imm(q_imm), .q_predicted(q_predicted), .q_trap(q_trap), .q_cause(q_cause),
    .fw_stall_id(fw_stall_id), .fw_stall_if(fw_stall_if),
    .fw_branch_predict(fw_branch_predict), .fw_branch_target(fw_branch_target)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:1] pc, input logic [31:0] insn,
                       input logic trap, input logic [3:0] cause);
    d_valid = v;
    d_pc    = pc;
    d_insn  = insn;
    d_trap  = trap;
    d_cause = cause;
  endtask

  task automatic expect_q(input logic v, input logic [31:1] pc, input logic [31:0] insn,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] imm, input logic pred, input logic trap,
                          input logic [3:0] cause, input logic fwp, input logic [31:1] tgt);
    exp_t e;
    e.v = v; e.pc = pc; e.insn = insn; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
    e.pred = pred; e.trap = trap; e.cause = cause; e.fwp = fwp; e.tgt = tgt;
    sb.push_back(e);
  endtask

  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".q_valid"},     {31'd0, q_valid},           {31'd0, e.v});
      chk({tag, ".q_pc"},        {1'b0, q_pc},               {1'b0, e.pc});
      chk({tag, ".q_insn"},      q_insn,                     e.insn);
      chk({tag, ".q_rs1"},       {27'd0, q_rs1},             {27'd0, e.rs1});
      chk({tag, ".q_rs2"},       {27'd0, q_rs2},             {27'd0, e.rs2});
      chk({tag, ".q_rd"},        {27'd0, q_rd},              {27'd0, e.rd});
      chk({tag, ".q_imm"},       q_imm,                      e.imm);
      chk({tag, ".q_predicted"}, {31'd0, q_predicted},       {31'd0, e.pred});
      chk({tag, ".q_trap"},      {31'd0, q_trap},            {31'd0, e.trap});
      chk({tag, ".q_cause"},     {28'd0, q_cause},           {28'd0, e.cause});
      chk({tag, ".predict"},     {31'd0, fw_branch_predict}, {31'd0, e.fwp});
      chk({tag, ".target"},      {1'b0, fw_branch_target},   {1'b0, e.tgt});
      chk({tag, ".stall_if"},    {31'd0, fw_stall_if},       {31'd0, fw_stall_id});
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; fw_stall_id = 1'b0;
    drive(1'b1, 31'h0000_0055, 32'h0080006F, 1'b1, 4'd7);
    expect_q(0, 31'd0, 32'h13, 0, 0, 0, 32'd0, 0, 0, 4'd0, 0, 31'd0);
    tick_check("reset");
    rst = 1'b0;

    drive(1'b1, 31'h1000_0000, 32'h00500093, 1'b0, 4'd0);
    expect_q(1, 31'h1000_0000, 32'h00500093, 0, 0, 1, 32'd5, 0, 0, 4'd0, 0, 31'h1000_0002);
    tick_check("addi");

    drive(1'b1, 31'h80, 32'h0080006F, 1'b0, 4'd0);
    expect_q(1, 31'h80, 32'h0080006F, 0, 0, 0, 32'd8, 1, 0, 4'd0, 1, 31'h84);
    tick_check("jal");

    drive(1'b1, 31'h84, 32'h00000013, 1'b0, 4'd0);
    expect_q(1, 31'h84, 32'h13, 0, 0, 0, 32'd0, 0, 0, 4'd0, 0, 31'h84);
    tick_check("after_jal");

    drive(1'b1, 31'h100, 32'hFE000EE3, 1'b0, 4'd0);
    expect_q(1, 31'h100, 32'hFE000EE3, 0, 0, 0, 32'hFFFF_FFFC, BTFN, 0, 4'd0, BTFN, 31'hFE);
    tick_check("beq_back");

    drive(1'b1, 31'h200, 32'hFE532C23, 1'b0, 4'd0);
    expect_q(1, 31'h200, 32'hFE532C23, 6, 5, 0, 32'hFFFF_FFF8, 0, 0, 4'd0, 0, 31'h1FC);
    tick_check("sw_wrap");

    drive(1'b1, 31'h300, 32'h123451B7, 1'b0, 4'd0);
    expect_q(1, 31'h300, 32'h123451B7, 0, 0, 3, 32'h1234_5000, 0, 0, 4'd0, 0, 31'h091A_2B00);
    tick_check("lui");

    drive(1'b1, 31'h400, 32'h40109093, 1'b0, 4'd0);
    expect_q(0, 31'h400, 32'h40109093, 1, 0, 1, 32'h401, 0, 1, `RV_ECAUSE_IINSN, 0, 31'h600);
    tick_check("bad_slli");

    drive(1'b1, 31'h500, 32'h00000000, 1'b0, 4'd0);
    expect_q(0, 31'h500, 32'h0, 0, 0, 0, 32'd0, 0, 1, `RV_ECAUSE_IINSN, 0, 31'h500);
    tick_check("zero_insn");

    drive(1'b1, 31'h600, 32'h00000000, 1'b1, `RV_ECAUSE_IALIGN);
    expect_q(0, 31'h600, 32'h0, 0, 0, 0, 32'd0, 0, 1, `RV_ECAUSE_IALIGN, 0, 31'h600);
    tick_check("if_trap");

    drive(1'b1, 31'h80, 32'h0080006F, 1'b0, 4'd0);
    expect_q(1, 31'h80, 32'h0080006F, 0, 0, 0, 32'd8, 1, 0, 4'd0, 1, 31'h84);
    tick_check("jal2");

    fw_stall_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 31'h999 + 31'(i), 32'h00500093, 1'b0, 4'd0);
      expect_q(1, 31'h80, 32'h0080006F, 0, 0, 0, 32'd8, 1, 0, 4'd0, 0, 31'h84);
      tick_check("stall_hold");
    end

    fw_stall_id = 1'b0;
    drive(1'b1, 31'h1000, 32'h00500093, 1'b0, 4'd0);
    #1;
    chk("release_predict", {31'd0, fw_branch_predict}, 32'd1);
    expect_q(1, 31'h1000, 32'h00500093, 0, 0, 1, 32'd5, 0, 0, 4'd0, 0, 31'h1002);
    tick_check("post_release");

    drive(1'b1, 31'h80, 32'h0080006F, 1'b0, 4'd0);
    expect_q(1, 31'h80, 32'h0080006F, 0, 0, 0, 32'd8, 1, 0, 4'd0, 1, 31'h84);
    tick_check("jal3");
    clear = 1'b1;
    drive(1'b1, 31'h700, 32'h00000013, 1'b0, 4'd0);
    #1;
    chk("clear_blocks_predict", {31'd0, fw_branch_predict}, 32'd0);
    expect_q(1, 31'h700, 32'h13, 0, 0, 0, 32'd0, 0, 0, 4'd0, 0, 31'h700);
    clear = 1'b0;
    tick_check("nop_after_clear");

    drive(1'b1, 31'h700, 32'h00000013, 1'b1, 4'd5);
    expect_q(0, 31'h700, 32'h13, 0, 0, 0, 32'd0, 0, 1, 4'd5, 0, 31'h700);
    tick_check("trap5");

    clear = 1'b1; fw_stall_id = 1'b1;
    drive(1'b1, 31'h800, 32'h00500093, 1'b0, 4'd0);
    expect_q(0, 31'h700, 32'h13, 0, 0, 0, 32'd0, 0, 0, 4'd0, 0, 31'h700);
    tick_check("clear_stall");
    clear = 1'b0; fw_stall_id = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/boa_stage_id.md
# boa_stage_id

Boa³² pipeline stage ID (instruction decode), directly downstream of the IF stage. It registers the IF/ID outputs and decodes RV32I fields and immediates for EX. It performs static branch prediction and feeds the predicted target back to IF. It also raises illegal-instruction traps and forwards IF traps.

## Interface
Parameters:
- none

Ports:
- clk  in  1  CPU clock.
- rst  in  1  Reset; synchronous, active-high.
- clear  in  1  Invalidate the ID result on the next edge.
- d_valid  in  1  IF/ID: result valid.
- d_pc  in  31 [31:1]  IF/ID: instruction PC.
- d_insn  in  32  IF/ID: instruction word.
- d_trap  in  1  IF/ID: trap raised.
- d_cause  in  4  IF/ID: trap cause.
- q_valid  out  1  ID/EX: result valid.
- q_pc  out  31 [31:1]  ID/EX: instruction PC.
- q_insn  out  32  ID/EX: raw instruction word.
- q_rs1, q_rs2, q_rd  out  5 each  Register indices; 0 when the format has no such field.
- q_imm  out  32  Sign-extended immediate for the I/S/B/U/J format; 0 for R-type.
- q_predicted  out  1  ID/EX: branch was predicted taken.
- q_trap  out  1  ID/EX: trap raised.
- q_cause  out  4  ID/EX: trap cause.
- fw_stall_id  in  1  Hold the ID register (EX hazard).
- fw_stall_if  out  1  Stall IF; equals fw_stall_id.
- fw_branch_predict  out  1  Predicted-taken control transfer.
- fw_branch_target  out  31 [31:1]  Predicted target.

## Operation
- Pipeline register r_valid/r_trap/r_cause/r_pc/r_insn is loaded from d_* when !fw_stall_id.
- While fw_stall_id=1, the register holds its value.
- clear=1 forces r_valid=0 and r_trap=0 on the edge, regardless of stall.
- Reset: r_valid=0, r_trap=0, r_pc=0, r_insn=32'h0000_0013 (NOP). As a result every q_* output resets to 0 except q_insn=0x13; q_imm, q_rs*, q_rd decode from the NOP.
- Decode is combinational from r_insn. The opcode class comes from insn[6:2]: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
- Immediates are formed per the RV32I formats, all sign-extended from insn[31].
- Illegal instruction: insn[1:0]≠2'b11, or an unlisted opcode, or invalid funct3/funct7 for OP/OP-IMM shifts. It yields q_trap=1, q_cause=`RV_ECAUSE_IINSN` and q_valid=0.
- A forwarded IF trap (r_trap=1) keeps its r_cause and takes priority over the illegal-instruction check.
- q_valid = r_valid && !illegal && !r_trap.
- q_trap = (r_valid && illegal) || r_trap.
- Prediction asserts fw_branch_predict = q_valid && !fw_stall_id && !clear && taken, where taken is:
  - JAL: always;
  - BRANCH: as defined under Configuration;
  - JALR: never (resolved in EX).
- fw_branch_target = r_pc + imm[31:1], with 31-bit wrap-around and no overflow trap.
- q_predicted = taken && q_valid.

## Timing
- Latency: 1 cycle from d_* to q_*.
- fw_branch_predict is combinational from the ID register. It is asserted in the same cycle the instruction is presented on q_*, and for exactly one cycle per instruction unless stalled.
- In the predict cycle, IF's sequential output is discarded by IF. The predicted target instruction arrives at d_* on a later cycle.
- If stall and predict coincide, predict is suppressed until the stall releases.
- If clear and stall coincide, clear wins.
- fw_stall_if has the same value as fw_stall_id.

## Configuration
- `BOA_BTFN_PREDICT_EN` defined: a BRANCH is predicted taken when imm is negative (backward-taken, forward-not-taken).
- Macro undefined: BRANCH is never predicted. Only JAL asserts fw_branch_predict, and q_predicted=0 for all branches.

## Test plan
- Reset, then d_valid=1, d_pc=0x2000_0000>>1, d_insn=0x00500093 (addi x1,x0,5) -> next cycle q_valid=1, q_rd=1, q_rs1=0, q_imm=5, fw_branch_predict=0.
- d_insn=0x0080006F (jal x0,+8) at PC 0x100 -> fw_branch_predict=1 for one cycle, fw_branch_target=0x108>>1, q_predicted=1.
- d_insn=0xFE000EE3 (beq x0,x0,-4) at PC 0x200 -> with macro: predict=1, target=0x1FC>>1. Without macro: predict=0.
- d_insn=0x0000_0000 -> q_valid=0, q_trap=1, q_cause=`RV_ECAUSE_IINSN`. Then d_trap=1, d_cause=`RV_ECAUSE_IALIGN` -> q_trap=1 with cause IALIGN.
- Hold fw_stall_id=1 for 3 cycles while d_* changes -> q_* stable, fw_stall_if=1, predict=0. On release, the held JAL asserts predict once.
- clear=1 together with fw_stall_id=1 -> next cycle q_valid=0, q_trap=0.
